// File: rtl/xcorr_pkg.sv
// Shared constants and FSM encoding for the cross-correlation peak picker.
package xcorr_pkg;
    localparam int LAG_CENTRE = 30;
    localparam int NUM_PAIRS  = 4;
    localparam int SB_W       = 9;
    localparam int LAG_W      = 6;

    typedef enum logic {SCAN, COMMIT} state_t;
endpackage

// File: rtl/xcorr_peak_picker_if.sv
// Per-lag correlation beat stream from the xcorr engine into the peak picker.
interface xcorr_peak_picker_if #(
    parameter int CORR_W   = 32,
    parameter int ENERGY_W = 24
);
    import xcorr_pkg::*;

    logic                       corr_valid;
    logic                       corr_ready;
    logic [1:0]                 corr_pair;
    logic [LAG_W-1:0]           corr_lag;
    logic signed [CORR_W-1:0]   corr_val;
    logic                       corr_last;
    logic [ENERGY_W-1:0]        energy;

    modport master (
        output corr_valid, corr_pair, corr_lag, corr_val, corr_last, energy,
        input  corr_ready
    );

    modport slave (
        input  corr_valid, corr_pair, corr_lag, corr_val, corr_last, energy,
        output corr_ready
    );
endinterface

// File: rtl/xcorr_argmax_lane.sv
// Running-max tracker shared by all pairs; nxt_lag already includes the current beat.
module xcorr_argmax_lane
    import xcorr_pkg::*;
#(
    parameter int CORR_W = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [CORR_W-1:0] val,
    input  logic [LAG_W-1:0]         lag,
    output logic [LAG_W-1:0]         nxt_lag
);
    logic signed [CORR_W-1:0] best_val_p1;
    logic [LAG_W-1:0]         best_lag_p1;
    logic                     take;

    // Strict compare: on a tie the earlier (lower) lag stays the winner.
    assign take    = load || (val > best_val_p1);
    assign nxt_lag = take ? lag : best_lag_p1;

    always_ff @(posedge clk) begin
        if (en && take) begin
            best_val_p1 <= val;
            best_lag_p1 <= lag;
        end
    end
endmodule

// File: rtl/xcorr_peak_picker.sv
// Per-pair argmax lag picker with gated loudness band; outputs update atomically per frame.
// Optional per-pair lag smoothing IIR is enabled by defining XCORR_SMOOTH_EN.
module xcorr_peak_picker
    import xcorr_pkg::*;
#(
    parameter int NUM_LAGS     = 61,
    parameter int CORR_W       = 32,
    parameter int ENERGY_W     = 24,
    parameter int ENERGY_SHIFT = 10,
    parameter int BAND_MIN     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    xcorr_peak_picker_if.slave  corr,
    output logic [LAG_W-1:0]    mic1,
    output logic [LAG_W-1:0]    mic2,
    output logic [LAG_W-1:0]    mic3,
    output logic [LAG_W-1:0]    mic4,
    output logic [SB_W-1:0]     sound_band,
    output logic                out_valid,
    output logic                frame_err
);
    state_t             state_q, state_d;
    logic [1:0]         exp_pair_q;
    logic [LAG_W-1:0]   exp_lag_q;
    logic               ready_c, commit, accept, beat_ok, restart, lane_en;
    logic [LAG_W-1:0]   lane_lag;
    logic [LAG_W-1:0]   pend_p1 [NUM_PAIRS];
    logic [LAG_W-1:0]   pub_lag [NUM_PAIRS];
    logic [ENERGY_W-1:0] energy_p1;

    function automatic logic [SB_W-1:0] band_sat(input logic [ENERGY_W-1:0] e_in);
        logic [ENERGY_W-1:0] e;
        e = e_in >> ENERGY_SHIFT;
        if (e < ENERGY_W'(BAND_MIN))              return '0;
        else if (e > ENERGY_W'((1 << SB_W) - 1))  return '1;
        else                                      return e[SB_W-1:0];
    endfunction

    assign accept  = corr.corr_valid && (state_q == SCAN);
    assign beat_ok = (corr.corr_pair == exp_pair_q) && (corr.corr_lag == exp_lag_q) &&
                     (corr.corr_last == (corr.corr_lag == LAG_W'(NUM_LAGS - 1)));
    assign restart = (corr.corr_pair == 2'd0) && (corr.corr_lag == '0);
    assign lane_en = accept && (beat_ok || restart);
    assign corr.corr_ready = ready_c;

    xcorr_argmax_lane #(.CORR_W(CORR_W)) u_lane (
        .clk     (clk),
        .en      (lane_en),
        .load    (corr.corr_lag == '0),
        .val     (corr.corr_val),
        .lag     (corr.corr_lag),
        .nxt_lag (lane_lag)
    );

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        commit  = 1'b0;
        case (state_q)
            SCAN: begin
                ready_c = 1'b1;
                if (accept && beat_ok && corr.corr_last && exp_pair_q == 2'd3)
                    state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    // Stage p0: beat acceptance, protocol tracking and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            exp_pair_q <= '0;
            exp_lag_q  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_err <= accept && !beat_ok;
            if (accept) begin
                if (beat_ok) begin
                    if (corr.corr_last) begin
                        exp_pair_q <= exp_pair_q + 2'd1;
                        exp_lag_q  <= '0;
                    end else begin
                        exp_lag_q  <= exp_lag_q + 1'b1;
                    end
                end else begin
                    exp_pair_q <= '0;
                    exp_lag_q  <= restart ? LAG_W'(1) : '0;
                end
            end
        end
    end

    // Stage p1: per-pair pending slots; a restarted frame overwrites every slot before commit.
    always_ff @(posedge clk) begin
        if (accept && beat_ok && corr.corr_last) begin
            pend_p1[exp_pair_q] <= lane_lag;
            if (exp_pair_q == 2'd3)
                energy_p1 <= corr.energy;
        end
    end

`ifdef XCORR_SMOOTH_EN
    logic [7:0] smooth_q [NUM_PAIRS];
    logic [7:0] smooth_d [NUM_PAIRS];
    logic       seeded_q;

    function automatic logic [7:0] iir_step(input logic [7:0] s, input logic [LAG_W-1:0] lag);
        return 8'({1'b0, s} - 9'(s >> 2) + 9'(lag));
    endfunction

    function automatic logic [LAG_W-1:0] round_q2(input logic [7:0] s);
        return LAG_W'(({1'b0, s} + 9'd2) >> 2);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PAIRS; i++) begin
            smooth_d[i] = seeded_q ? iir_step(smooth_q[i], pend_p1[i]) : {pend_p1[i], 2'b00};
            pub_lag[i]  = round_q2(smooth_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded_q <= 1'b0;
            for (int i = 0; i < NUM_PAIRS; i++) smooth_q[i] <= 8'(LAG_CENTRE << 2);
        end else if (commit) begin
            seeded_q <= 1'b1;
            for (int i = 0; i < NUM_PAIRS; i++) smooth_q[i] <= smooth_d[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_PAIRS; i++) pub_lag[i] = pend_p1[i];
    end
`endif

    // Stage p2: published outputs, registered at the end of the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mic1       <= LAG_W'(LAG_CENTRE);
            mic2       <= LAG_W'(LAG_CENTRE);
            mic3       <= LAG_W'(LAG_CENTRE);
            mic4       <= LAG_W'(LAG_CENTRE);
            sound_band <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= commit;
            if (commit) begin
                mic1       <= pub_lag[0];
                mic2       <= pub_lag[1];
                mic3       <= pub_lag[2];
                mic4       <= pub_lag[3];
                sound_band <= band_sat(energy_p1);
            end
        end
    end
endmodule

// File: tb/tb_xcorr_peak_picker.sv
// Directed bench for xcorr_peak_picker with an expected-result queue checked on out_valid.
module tb_xcorr_peak_picker;
    import xcorr_pkg::*;

    localparam int NL = 61;

    typedef struct packed {
        logic [5:0] m0, m1, m2, m3;
        logic [8:0] sb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] mic1, mic2, mic3, mic4;
    logic [8:0] sound_band;
    logic       out_valid, frame_err;

    xcorr_peak_picker_if #(.CORR_W(32), .ENERGY_W(24)) bus ();

    xcorr_peak_picker #(
        .NUM_LAGS(61), .CORR_W(32), .ENERGY_W(24), .ENERGY_SHIFT(10), .BAND_MIN(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .corr       (bus.slave),
        .mic1       (mic1),
        .mic2       (mic2),
        .mic3       (mic3),
        .mic4       (mic4),
        .sound_band (sound_band),
        .out_valid  (out_valid),
        .frame_err  (frame_err)
    );

    exp_t sb_q[$];
    exp_t last_pub;
    int   checks = 0;
    int   failures = 0;
    int   pat = 0;
    int   peak[4];
    int   s_m[4];
    bit   seeded_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] cval(input int p, input int l);
        if (pat == 1 && p == 0) return (l == 12 || l == 47) ? 32'sd500 : 32'($urandom_range(0, 400));
        if (pat == 1 && p == 1) return -32'sd5;
        if (l == peak[p]) return 32'sd1000;
        return -32'sd100 - 32'(l) + 32'($urandom_range(0, 900));
    endfunction

    task automatic model_reset();
        seeded_m = 1'b0;
        for (int i = 0; i < 4; i++) s_m[i] = 120;
    endtask

    task automatic push_exp(input int r0, input int r1, input int r2, input int r3, input int sb);
        int r[4];
        int m[4];
        exp_t x;
        r = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
`ifdef XCORR_SMOOTH_EN
            if (!seeded_m) s_m[i] = r[i] * 4;
            else           s_m[i] = s_m[i] - (s_m[i] / 4) + r[i];
            m[i] = (s_m[i] + 2) / 4;
`else
            m[i] = r[i];
`endif
        end
        seeded_m = 1'b1;
        x.m0 = 6'(m[0]); x.m1 = 6'(m[1]); x.m2 = 6'(m[2]); x.m3 = 6'(m[3]);
        x.sb = 9'(sb);
        sb_q.push_back(x);
    endtask

    task automatic send_beat(input int p, input int l, input logic [23:0] en);
        int waitc;
        waitc = 0;
        @(negedge clk);
        bus.corr_valid = 1'b1;
        bus.corr_pair  = 2'(p);
        bus.corr_lag   = 6'(l);
        bus.corr_val   = cval(p, l);
        bus.corr_last  = (l == NL - 1);
        bus.energy     = en;
        while (bus.corr_ready !== 1'b1 && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 8) check("ready_timeout", 32'(bus.corr_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_pair(input int p, input int from, input int to, input logic [23:0] en);
        for (int l = from; l <= to; l++) send_beat(p, l, en);
    endtask

    task automatic send_frame(input logic [23:0] en);
        for (int p = 0; p < 4; p++) send_pair(p, 0, NL - 1, en);
    endtask

    task automatic set_peaks(input int a, input int b, input int c, input int d);
        peak = '{a, b, c, d};
    endtask

    // Commit timing: ready low and no pulse at N+1, pulse and ready back at N+2.
    task automatic check_commit_timing();
        @(negedge clk);
        bus.corr_valid = 1'b0;
        check("ready_in_commit", 32'(bus.corr_ready), 32'd0);
        check("out_valid_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("out_valid_n2", 32'(out_valid), 32'd1);
        check("ready_after_commit", 32'(bus.corr_ready), 32'd1);
        @(negedge clk);
        check("out_valid_single", 32'(out_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("mic1", 32'(mic1), 32'(e.m0));
                check("mic2", 32'(mic2), 32'(e.m1));
                check("mic3", 32'(mic3), 32'(e.m2));
                check("mic4", 32'(mic4), 32'(e.m3));
                check("sound_band", 32'(sound_band), 32'(e.sb));
                last_pub = e;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.corr_valid = 1'b0;
        bus.corr_pair  = '0;
        bus.corr_lag   = '0;
        bus.corr_val   = '0;
        bus.corr_last  = 1'b0;
        bus.energy     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mic1", 32'(mic1), 32'd30);
        check("rst_mic2", 32'(mic2), 32'd30);
        check("rst_mic3", 32'(mic3), 32'd30);
        check("rst_mic4", 32'(mic4), 32'd30);
        check("rst_sound_band", 32'(sound_band), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_ready", 32'(bus.corr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single spikes per pair, mid-range energy
        pat = 0; set_peaks(40, 30, 10, 55);
        push_exp(40, 30, 10, 55, 300);
        send_frame(24'(300 << 10));
        check_commit_timing();

        // Ties keep the lower lag, flat pair picks lag 0, silence gate
        pat = 1; set_peaks(0, 0, 5, 60);
        push_exp(12, 0, 5, 60, 0);
        send_frame(24'(2 << 10));
        check_commit_timing();

        // Edge lags and full-scale energy saturation
        pat = 0; set_peaks(0, 60, 33, 1);
        push_exp(0, 60, 33, 1, 511);
        send_frame(24'hFFFFFF);
        check_commit_timing();

        // Energy exactly at the gate threshold
        set_peaks(20, 21, 22, 23);
        push_exp(20, 21, 22, 23, 4);
        send_frame(24'(4 << 10));
        check_commit_timing();

        // Energy just above the 9-bit ceiling
        set_peaks(59, 2, 44, 17);
        push_exp(59, 2, 44, 17, 511);
        send_frame(24'(512 << 10));
        check_commit_timing();

        // Lag skip in pair 1: error pulse, published outputs hold
        set_peaks(25, 26, 27, 28);
        send_pair(0, 0, NL - 1, 24'd0);
        send_pair(1, 0, 20, 24'd0);
        send_beat(1, 22, 24'd0);
        @(negedge clk);
        bus.corr_valid = 1'b0;
        check("err_skip_pulse", 32'(frame_err), 32'd1);
        check("hold_mic1", 32'(mic1), 32'(last_pub.m0));
        check("hold_mic4", 32'(mic4), 32'(last_pub.m3));
        check("hold_sound_band", 32'(sound_band), 32'(last_pub.sb));
        @(negedge clk);
        check("err_skip_single", 32'(frame_err), 32'd0);

        // Clean frame after the error, energy just below the gate
        push_exp(25, 26, 27, 28, 0);
        send_frame(24'((3 << 10) + 1023));
        check_commit_timing();

        // Pair 0 / lag 0 mid-frame restarts the frame
        set_peaks(7, 8, 9, 11);
        send_pair(0, 0, 30, 24'(511 << 10));
        send_beat(0, 0, 24'(511 << 10));
        @(negedge clk);
        bus.corr_valid = 1'b0;
        check("err_restart_pulse", 32'(frame_err), 32'd1);
        push_exp(7, 8, 9, 11, 511);
        send_pair(0, 1, NL - 1, 24'(511 << 10));
        for (int p = 1; p < 4; p++) send_pair(p, 0, NL - 1, 24'(511 << 10));
        check_commit_timing();

        // Asynchronous reset during pair 2
        set_peaks(45, 46, 47, 48);
        send_pair(0, 0, NL - 1, 24'(100 << 10));
        send_pair(1, 0, NL - 1, 24'(100 << 10));
        send_pair(2, 0, 10, 24'(100 << 10));
        @(negedge clk);
        bus.corr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_mic1", 32'(mic1), 32'd30);
        check("arst_mic2", 32'(mic2), 32'd30);
        check("arst_mic3", 32'(mic3), 32'd30);
        check("arst_mic4", 32'(mic4), 32'd30);
        check("arst_sound_band", 32'(sound_band), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_frame_err", 32'(frame_err), 32'd0);
        check("post_rst_ready", 32'(bus.corr_ready), 32'd1);

        // Lag 30 then constant lag 50, frames back to back through COMMIT
        set_peaks(30, 30, 30, 30);
        push_exp(30, 30, 30, 30, 100);
        send_frame(24'(100 << 10));
        set_peaks(50, 50, 50, 50);
        for (int f = 0; f < 3; f++) begin
            push_exp(50, 50, 50, 50, 100);
            send_frame(24'(100 << 10));
        end
        check_commit_timing();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xcorr_peak_picker.md
Name: xcorr_peak_picker

Overview:
- Sits directly upstream of the overlay/heat-map stage.
- Consumes the cross-correlation engine's per-lag output stream for the 4 mic pairs and finds the argmax lag of each pair.
- Publishes the four 6-bit lag indices (centre = 30) plus a 9-bit sound_band loudness level, updated atomically once per frame.
- The overlay stage samples these at frame start; this block holds them stable between updates.

Parameters:
- NUM_LAGS, 61, lags per pair, indices 0..NUM_LAGS-1; lag 30 = zero delay. Must be ≤ 64.
- CORR_W, 32, width of signed correlation value.
- ENERGY_W, 24, width of unsigned frame energy.
- ENERGY_SHIFT, 10, right shift applied to energy before saturation to 9 bits.
- BAND_MIN, 4, shifted-energy values below this force sound_band = 0 (silence gate).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- corr_valid  in  1  correlation beat valid
- corr_ready  out  1  block accepts a beat when corr_valid && corr_ready
- corr_pair  in  2  pair index 0..3
- corr_lag  in  6  lag index
- corr_val  in  CORR_W  signed correlation value
- corr_last  in  1  last lag of the current pair
- energy  in  ENERGY_W  frame energy, sampled on the accepted pair-3 last beat
- mic1, mic2, mic3, mic4  out  6 each  argmax lag of pairs 0..3
- sound_band  out  9  gated, saturated loudness
- out_valid  out  1  one-cycle pulse when outputs update
- frame_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async assert, sync release) sets:
  - mic1..mic4 = 30, sound_band = 0, out_valid = 0, frame_err = 0, corr_ready = 1.
  - FSM = SCAN, expected pair = 0, expected lag = 0.
- FSM has two states, SCAN and COMMIT.
- SCAN, per accepted beat:
  - Check: corr_pair == expected pair, corr_lag == expected lag, and corr_last == (corr_lag == NUM_LAGS-1).
  - Lag 0 of a pair loads best_val/best_lag from the beat.
  - Later lags replace the best only if corr_val > best_val (signed, strictly greater). Ties keep the lower lag.
  - On last: latch best_lag into a pending slot for that pair, then advance to the next pair at lag 0.
  - Last of pair 3: also latch the energy input, then go to COMMIT.
- Protocol error (any check fails):
  - Pulse frame_err the next cycle, discard all pending slots, reset expectation to pair 0 / lag 0.
  - If the offending beat is itself pair 0 / lag 0, it is accepted as the start of a new frame; otherwise it is dropped.
  - Published outputs are not changed.
- COMMIT (one cycle): corr_ready = 0; upstream must hold its beat. Outputs are registered at the end of this cycle.
- Update timing and values:
  - Last beat accepted at cycle N → new mic*/sound_band and out_valid = 1 visible at N+2.
  - corr_ready returns to 1 at N+2.
  - Pending slots map directly to mic1..mic4 (pair 0..3).
- sound_band computation:
  - e = energy >> ENERGY_SHIFT.
  - If e < BAND_MIN, sound_band = 0.
  - Else if e > 511, sound_band = 511.
  - Else sound_band = e.
- All comparisons are signed on CORR_W bits; no accumulation, so no overflow.
- Reset mid-frame discards partial results, with no out_valid and no frame_err.

Optional Feature:
- Macro XCORR_SMOOTH_EN.
- Defined: per-pair 8-bit IIR with 2 fraction bits.
  - s' = s − (s>>2) + lag_new; output mic = (s' + 2) >> 2.
  - The first committed frame after reset seeds s = lag_new<<2.
  - Reset value of s = 120, i.e. output 30.
  - The extra state and arithmetic are registered in the COMMIT cycle, so latency is unchanged.
- Undefined: raw argmax is published, and no smoothing registers exist.
- sound_band is never smoothed.

Decomposition:
- Package xcorr_pkg holds:
  - LAG_CENTRE = 30, NUM_PAIRS = 4.
  - SB_W = 9, LAG_W = 6.
  - FSM state enum {SCAN, COMMIT}.
- One natural sub-module, xcorr_argmax_lane: a single running-max tracker (best_val/best_lag, load on lag 0, strict-greater update).
  - Instantiated once and time-shared across pairs, since pairs stream sequentially.

Test Plan:
- Frame where pair p has a single spike at lags 40, 30, 10, 55, with energy = 300<<10 → mic1..4 = 40, 30, 10, 55; sound_band = 300; out_valid pulses exactly at N+2; corr_ready is low for one cycle.
- Pair 0 equal maxima at lags 12 and 47 → mic1 = 12. Pair 1 all values −5 → mic2 = 0. energy = 2<<10 → sound_band = 0. energy = 0xFFFFFF → sound_band = 511.
- Pair 1 stream jumps from lag 20 to lag 22 → frame_err pulse, outputs still hold the previous frame. A following clean frame publishes correctly.
- Error beat that is pair 0 / lag 0 mid-frame → frame_err pulses and that beat starts a new frame; the next full frame commits.
- rst_n asserted during pair 2 → outputs 30/30/30/30 and 0 immediately (async); no out_valid until a full frame completes after release.
- With XCORR_SMOOTH_EN: frame 1 lag 30, then constant lag 50 → mic1 = 30, then 35, 39, 42, … converging to 50 (re-verify each value from the IIR equation). Without the macro: 30, then 50.
